// File: rtl/com_fifo_wr_arb.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// BURST beats into a downstream FIFO, gated by FIFO full and water level.
module com_fifo_wr_arb #(
   parameter int DW     = 8,
   parameter int NREQ   = 4,
   parameter int DEPTH  = 4,
   parameter int BURST  = 2,
   parameter int AF_LVL = 3,
   localparam int IW    = $clog2(NREQ),
   localparam int BW    = $clog2(BURST + 1),
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic [NREQ-1:0]    req_vld,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_rdy,
   output logic               fifo_wr_en,
   output logic [DW-1:0]      fifo_wr_data,
   input  logic               fifo_wr_full,
   input  logic [LW-1:0]      fifo_water_level,
   output logic [IW-1:0]      grant_id,
   output logic               busy
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;

   logic [0:0]    r_state;
   logic [IW-1:0] r_grant_id;
   logic [IW-1:0] r_rr_ptr;
   logic [BW-1:0] r_beat_cnt;

   logic          w_flush;
   logic          w_room;
   logic          w_found;
   logic [IW-1:0] w_sel;
   logic          w_owner_vld;
   logic          w_can_wr;
   logic          w_xfer;
   logic          w_last;
   logic [IW-1:0] w_rr_next;

   assign w_flush = rst | clear;
   assign w_room  = int'(fifo_water_level) < AF_LVL;

   // First valid requester at or after the round-robin pointer, wrapping.
   always_comb begin
      int idx;
      w_found = 1'b0;
      w_sel   = '0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!w_found && req_vld[idx]) begin
            w_found = 1'b1;
            w_sel   = IW'(idx);
         end
      end
   end

   assign w_owner_vld = req_vld[r_grant_id];
   // Flush gates the handshake in the same cycle so a burst can be cut cleanly.
   assign w_can_wr    = (r_state == S_GRANT) & ~fifo_wr_full & ~w_flush;
   assign w_xfer      = w_can_wr & w_owner_vld;
   assign w_last      = (r_beat_cnt == BW'(BURST - 1));
   assign w_rr_next   = (r_grant_id == IW'(NREQ - 1)) ? '0 : r_grant_id + IW'(1);

   always_comb begin
      req_rdy = '0;
      if (w_can_wr) req_rdy[r_grant_id] = 1'b1;
   end

   assign fifo_wr_en   = w_xfer;
   assign fifo_wr_data = w_xfer ? req_data[r_grant_id*DW +: DW] : '0;
   assign grant_id     = r_grant_id;
   assign busy         = (r_state == S_GRANT);

   always_ff @(posedge clk) begin
      if (w_flush) begin
         r_state    <= S_IDLE;
         r_grant_id <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found && w_room) begin
                  r_state    <= S_GRANT;
                  r_grant_id <= w_sel;
                  r_beat_cnt <= '0;
               end
            end
            S_GRANT: begin
               if (!w_owner_vld || (w_xfer && w_last)) begin
                  r_state    <= S_IDLE;
                  r_rr_ptr   <= w_rr_next;
                  r_beat_cnt <= '0;
               end else if (w_xfer) begin
                  r_beat_cnt <= r_beat_cnt + BW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_com_fifo_wr_arb.sv
// Directed bench for com_fifo_wr_arb: reset, round-robin order, early release,
// full stall, water-level gate and clear mid-burst.
module tb_com_fifo_wr_arb;

   logic        clk;
   logic        rst;
   logic        clear;
   logic [3:0]  req_vld;
   logic [31:0] req_data;
   logic [3:0]  req_rdy;
   logic        fifo_wr_en;
   logic [7:0]  fifo_wr_data;
   logic        fifo_wr_full;
   logic [2:0]  fifo_water_level;
   logic [1:0]  grant_id;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   com_fifo_wr_arb #(.DW(8), .NREQ(4), .DEPTH(4), .BURST(2), .AF_LVL(3)) dut (
      .clk              (clk),
      .rst              (rst),
      .clear            (clear),
      .req_vld          (req_vld),
      .req_data         (req_data),
      .req_rdy          (req_rdy),
      .fifo_wr_en       (fifo_wr_en),
      .fifo_wr_data     (fifo_wr_data),
      .fifo_wr_full     (fifo_wr_full),
      .fifo_water_level (fifo_water_level),
      .grant_id         (grant_id),
      .busy             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic       exp_en  [13] = '{1,1,0,1,1,0,1,1,0,1,1,0,1};
   logic [7:0] exp_d   [13] = '{8'hA0,8'hA0,8'h00,8'hA1,8'hA1,8'h00,8'hA2,8'hA2,8'h00,
                                8'hA3,8'hA3,8'h00,8'hA0};
   logic [3:0] exp_rdy [13] = '{4'b0001,4'b0001,4'b0000,4'b0010,4'b0010,4'b0000,
                                4'b0100,4'b0100,4'b0000,4'b1000,4'b1000,4'b0000,4'b0001};

   initial begin
      rst = 1'b1; clear = 1'b0; req_vld = 4'b1111; fifo_wr_full = 1'b0;
      fifo_water_level = 3'd0; req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

      // Reset held three cycles with everyone requesting
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_rdy", 32'(req_rdy), 32'h0);
         chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
      end
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_gid", 32'(grant_id), 32'h0);
      chk("rst_wdata", 32'(fifo_wr_data), 32'h0);
      chk("rst_rr", 32'(dut.r_rr_ptr), 32'h0);
      chk("rst_beat", 32'(dut.r_beat_cnt), 32'h0);

      rst = 1'b0;
      #1;
      chk("rel_busy", 32'(busy), 32'h0);
      chk("rel_wr_en", 32'(fifo_wr_en), 32'h0);
      tick();
      chk("rel_gid", 32'(grant_id), 32'h0);
      chk("rel_busy1", 32'(busy), 32'h1);

      // Round-robin write stream
      for (int i = 0; i < 13; i++) begin
         chk($sformatf("rr_en[%0d]", i), 32'(fifo_wr_en), 32'(exp_en[i]));
         chk($sformatf("rr_data[%0d]", i), 32'(fifo_wr_data), 32'(exp_d[i]));
         chk($sformatf("rr_rdy[%0d]", i), 32'(req_rdy), 32'(exp_rdy[i]));
         tick();
      end

      // Reset mid-burst (second beat of requester 0) kills the write at once
      rst = 1'b1;
      #1;
      chk("rst_mid_wr_en", 32'(fifo_wr_en), 32'h0);
      chk("rst_mid_rdy", 32'(req_rdy), 32'h0);
      tick();
      rst = 1'b0; req_vld = 4'b0000;

      // Early release: requester 1 presents a single beat
      req_vld = 4'b0010; req_data[15:8] = 8'h11;
      #1;
      chk("er_idle", 32'(busy), 32'h0);
      tick();
      chk("er_gid", 32'(grant_id), 32'h1);
      chk("er_wr_en", 32'(fifo_wr_en), 32'h1);
      chk("er_data", 32'(fifo_wr_data), 32'h11);
      tick();
      req_vld = 4'b0000;
      #1;
      chk("er_busy_hold", 32'(busy), 32'h1);
      chk("er_no_wr", 32'(fifo_wr_en), 32'h0);
      chk("er_wdata0", 32'(fifo_wr_data), 32'h0);
      tick();
      chk("er_back_idle", 32'(busy), 32'h0);
      chk("er_rr", 32'(dut.r_rr_ptr), 32'h2);

      // Full stall after the first beat of requester 2
      req_vld = 4'b0100; req_data[23:16] = 8'h22;
      tick();
      chk("fs_gid", 32'(grant_id), 32'h2);
      chk("fs_beat1_data", 32'(fifo_wr_data), 32'h22);
      tick();
      fifo_wr_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("fs_rdy[%0d]", i), 32'(req_rdy), 32'h0);
         chk($sformatf("fs_wr_en[%0d]", i), 32'(fifo_wr_en), 32'h0);
         chk($sformatf("fs_gid[%0d]", i), 32'(grant_id), 32'h2);
         chk($sformatf("fs_beat[%0d]", i), 32'(dut.r_beat_cnt), 32'h1);
         tick();
      end
      fifo_wr_full = 1'b0; req_data[23:16] = 8'h23;
      #1;
      chk("fs_beat2_en", 32'(fifo_wr_en), 32'h1);
      chk("fs_beat2_data", 32'(fifo_wr_data), 32'h23);
      chk("fs_beat2_rdy", 32'(req_rdy), 32'h4);
      tick();
      req_vld = 4'b0000;
      #1;
      chk("fs_idle", 32'(busy), 32'h0);
      chk("fs_rr", 32'(dut.r_rr_ptr), 32'h3);

      // Water-level gate holds off a new grant
      req_vld = 4'b0100; fifo_water_level = 3'd3;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk($sformatf("wl_busy[%0d]", i), 32'(busy), 32'h0);
         chk($sformatf("wl_rdy[%0d]", i), 32'(req_rdy), 32'h0);
         chk($sformatf("wl_wr_en[%0d]", i), 32'(fifo_wr_en), 32'h0);
         tick();
      end
      fifo_water_level = 3'd2;
      #1;
      chk("wl_still_idle", 32'(busy), 32'h0);
      tick();
      chk("wl_busy", 32'(busy), 32'h1);
      chk("wl_gid", 32'(grant_id), 32'h2);
      chk("wl_wr_data", 32'(fifo_wr_data), 32'h23);
      tick();
      req_vld = 4'b0000; fifo_water_level = 3'd0;
      #1;
      chk("wl_rel_no_wr", 32'(fifo_wr_en), 32'h0);
      tick();
      chk("wl_idle", 32'(busy), 32'h0);
      chk("wl_rr", 32'(dut.r_rr_ptr), 32'h3);

      // Clear mid-burst on requester 3
      req_vld = 4'b1000;
      tick();
      chk("cl_gid", 32'(grant_id), 32'h3);
      chk("cl_first_data", 32'(fifo_wr_data), 32'hA3);
      tick();
      clear = 1'b1; req_vld = 4'b1111;
      #1;
      chk("cl_wr_en", 32'(fifo_wr_en), 32'h0);
      chk("cl_rdy", 32'(req_rdy), 32'h0);
      tick();
      clear = 1'b0;
      #1;
      chk("cl_idle", 32'(busy), 32'h0);
      chk("cl_rr", 32'(dut.r_rr_ptr), 32'h0);
      chk("cl_beat", 32'(dut.r_beat_cnt), 32'h0);
      tick();
      chk("cl_next_gid", 32'(grant_id), 32'h0);
      chk("cl_next_data", 32'(fifo_wr_data), 32'hA0);
      chk("cl_next_rdy", 32'(req_rdy), 32'h1);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
